pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, counter widths, default timings.
// Zero latency (types only); no backpressure.
// No handshake of its own; consumed by pipe_hazard_ctrl, its interface and hazard_cmp.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W       = 5;
    localparam int unsigned PERF_W          = 32;
    localparam int unsigned FLUSH_CYC_DEF   = 1;
    localparam int unsigned MDU_TIMEOUT_DEF = 64;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [PERF_W-1:0]    perf_cnt_t;
    typedef logic [3:0]           flush_cnt_t;
    typedef logic [7:0]           wait_cnt_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MDU_WAIT = 2'd2
    } hz_state_t;

    // A pipeline stage that may write the register file.
    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
    } prod_t;

    // Register sources read by the instruction in ID.
    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use_rs1;
        logic     use_rs2;
    } src_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register indices in, stall/flush/valid controls out.
// Zero latency (wires only); no backpressure.
// master = pipeline datapath, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t  id_rs1;
    reg_idx_t  id_rs2;
    logic      id_use_rs1;
    logic      id_use_rs2;
    reg_idx_t  ex_rd;
    logic      ex_reg_write;
    logic      ex_is_load;
    logic      ex_pc_sel;
    logic      ex_mdu_start;
    logic      mdu_done;
    reg_idx_t  mem_rd;
    logic      mem_reg_write;

    logic      pc_stall;
    logic      if_id_stall;
    logic      if_id_flush;
    logic      id_ex_valid;
    logic      id_ex_stall;
    logic      ex_mem_valid;
    logic      mdu_timeout;
    perf_cnt_t stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_reg_write, ex_is_load, ex_pc_sel, ex_mdu_start, mdu_done,
        output mem_rd, mem_reg_write,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_valid, id_ex_stall, ex_mem_valid,
        input  mdu_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_reg_write, ex_is_load, ex_pc_sel, ex_mdu_start, mdu_done,
        input  mem_rd, mem_reg_write,
        output pc_stall, if_id_stall, if_id_flush, id_ex_valid, id_ex_stall, ex_mem_valid,
        output mdu_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// RAW match between one producing stage and the sources of the instruction in ID.
// Combinational, zero latency; no backpressure.
// x0 is hardwired zero, so a producer targeting index 0 never matches.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  prod_t prod,
    input  src_t  src,
    output logic  hit
);

    assign hit = prod.wr && (prod.rd != '0) &&
                 ((src.use_rs1 && (src.rs1 == prod.rd)) ||
                  (src.use_rs2 && (src.rs2 == prod.rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, multi-cycle MDU hold with timeout, RAW stall; HAZARD_FORWARD_EN = load-use only.
// Controls are combinational from state and current inputs (zero latency); counters/flag update on sys_clk.
// Backpressure is the output: pc/if_id/id_ex stalls hold the front end, valids inject bubbles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC   = FLUSH_CYC_DEF,
    parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam flush_cnt_t FLUSH_RELOAD = flush_cnt_t'(FLUSH_CYC - 1);
    localparam wait_cnt_t  WAIT_LAST    = wait_cnt_t'(MDU_TIMEOUT - 1);

    hz_state_t  state_q, state_d, state_eff;
    flush_cnt_t flush_cnt_q, flush_cnt_d;
    wait_cnt_t  wait_cnt_q, wait_cnt_d;
    logic       timeout_set;
    logic       mdu_to_q;
    perf_cnt_t  stall_cnt_q;

    prod_t ex_prod, mem_prod;
    src_t  id_src;
    logic  ex_hit, mem_hit, data_hazard;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_valid, id_ex_stall, ex_mem_valid;

    assign id_src = '{rs1: hz.id_rs1, rs2: hz.id_rs2,
                      use_rs1: hz.id_use_rs1, use_rs2: hz.id_use_rs2};

`ifdef HAZARD_FORWARD_EN
    // Bypass covers everything except a load whose data only exists after MEM.
    assign ex_prod  = '{rd: hz.ex_rd, wr: hz.ex_reg_write && hz.ex_is_load};
    assign mem_prod = '{rd: hz.mem_rd, wr: 1'b0};
`else
    assign ex_prod  = '{rd: hz.ex_rd, wr: hz.ex_reg_write};
    assign mem_prod = '{rd: hz.mem_rd, wr: hz.mem_reg_write};
`endif

    hazard_cmp u_cmp_ex  (.prod(ex_prod),  .src(id_src), .hit(ex_hit));
    hazard_cmp u_cmp_mem (.prod(mem_prod), .src(id_src), .hit(mem_hit));

    assign data_hazard = ex_hit || mem_hit;

    // While reset is held the outputs behave as RUN, whatever the register still says.
    assign state_eff = sys_rst ? state_q : ST_RUN;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mdu_to_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            if (timeout_set)
                mdu_to_q <= 1'b1;
            if (pc_stall)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.ex_pc_sel) begin
                    flush_cnt_d = FLUSH_RELOAD;
                    if (FLUSH_CYC > 1)
                        state_d = ST_FLUSH;
                end else if (hz.ex_mdu_start && !hz.mdu_done) begin
                    state_d    = ST_MDU_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (hz.ex_pc_sel) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= flush_cnt_t'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (hz.mdu_done) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_RUN;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_valid  = 1'b1;
        id_ex_stall  = 1'b0;
        ex_mem_valid = 1'b1;
        case (state_eff)
            ST_RUN: begin
                if (hz.ex_pc_sel) begin
                    if_id_flush = 1'b1;
                    id_ex_valid = 1'b0;
                end else if (hz.ex_mdu_start) begin
                    if (!hz.mdu_done) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_valid = 1'b0;
                    end
                end else if (data_hazard) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_valid = 1'b0;
                end
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_valid = 1'b0;
            end
            ST_MDU_WAIT: begin
                // The timeout cycle already releases the holds.
                if (!hz.mdu_done && (wait_cnt_q != WAIT_LAST)) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_valid = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_valid  = id_ex_valid;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.ex_mem_valid = ex_mem_valid;
    assign hz.mdu_timeout  = mdu_to_q;
    assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a cycle-level model.
// dut0 uses FLUSH_CYC=3 / MDU_TIMEOUT=64, dut1 uses MDU_TIMEOUT=8 for the timeout case.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FLUSH_T = 3;
    localparam int unsigned MDU_TO0 = 64;
    localparam int unsigned MDU_TO1 = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_stalls = 0;

    // Model state: pending flush cycles, MDU wait progress, sticky timeout.
    int   m_flush_left = 0;
    bit   m_mdu_busy = 0;
    int   m_mdu_stalled = 0;
    bit   m_to = 0;

    pipe_hazard_ctrl_if if0 ();
    pipe_hazard_ctrl_if if1 ();

    pipe_hazard_ctrl #(.FLUSH_CYC(FLUSH_T), .MDU_TIMEOUT(MDU_TO0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz(if0));
    pipe_hazard_ctrl #(.FLUSH_CYC(1), .MDU_TIMEOUT(MDU_TO1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz(if1));

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle0();
        if0.id_rs1 = '0; if0.id_rs2 = '0; if0.id_use_rs1 = 0; if0.id_use_rs2 = 0;
        if0.ex_rd = '0; if0.ex_reg_write = 0; if0.ex_is_load = 0; if0.ex_pc_sel = 0;
        if0.ex_mdu_start = 0; if0.mdu_done = 0; if0.mem_rd = '0; if0.mem_reg_write = 0;
    endtask

    task automatic idle1();
        if1.id_rs1 = '0; if1.id_rs2 = '0; if1.id_use_rs1 = 0; if1.id_use_rs2 = 0;
        if1.ex_rd = '0; if1.ex_reg_write = 0; if1.ex_is_load = 0; if1.ex_pc_sel = 0;
        if1.ex_mdu_start = 0; if1.mdu_done = 0; if1.mem_rd = '0; if1.mem_reg_write = 0;
    endtask

    function automatic bit reads(logic [4:0] rd, logic wr);
        return wr && rd != 0 &&
               ((if0.id_use_rs1 && if0.id_rs1 == rd) || (if0.id_use_rs2 && if0.id_rs2 == rd));
    endfunction

    // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_valid, id_ex_stall, ex_mem_valid}
    // for the current inputs of dut0; advances the model by one cycle.
    task automatic model_step(output logic [5:0] e);
        bit ps = 0, fl = 0, iv = 1, ies = 0, emv = 1, haz;
`ifdef HAZARD_FORWARD_EN
        haz = reads(if0.ex_rd, if0.ex_reg_write && if0.ex_is_load);
`else
        haz = reads(if0.ex_rd, if0.ex_reg_write) || reads(if0.mem_rd, if0.mem_reg_write);
`endif
        if (m_flush_left > 0) begin
            fl = 1; iv = 0;
            m_flush_left = if0.ex_pc_sel ? int'(FLUSH_T) - 1 : m_flush_left - 1;
        end else if (m_mdu_busy) begin
            if (if0.mdu_done) m_mdu_busy = 0;
            else if (m_mdu_stalled == int'(MDU_TO0)) begin m_mdu_busy = 0; m_to = 1; end
            else begin ps = 1; ies = 1; emv = 0; m_mdu_stalled++; end
        end else if (if0.ex_pc_sel) begin
            fl = 1; iv = 0;
            m_flush_left = int'(FLUSH_T) - 1;
        end else if (if0.ex_mdu_start) begin
            if (!if0.mdu_done) begin ps = 1; ies = 1; emv = 0; m_mdu_busy = 1; m_mdu_stalled = 1; end
        end else if (haz) begin
            ps = 1; iv = 0;
        end
        if (ps) exp_stalls++;
        e = {ps, ps, fl, iv, ies, emv};
    endtask

    task automatic test_reset();
        idle0(); idle1();
        sys_rst = 0;
        tick(); tick();
        if0.ex_rd = 3; if0.ex_reg_write = 1; if0.id_rs1 = 3; if0.id_use_rs1 = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b1 || if0.id_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_run_hazard: pc_stall=%b id_ex_valid=%b, want 1 0", if0.pc_stall, if0.id_ex_valid); end
        n_chk++; if (if0.stall_cycles !== 32'd0 || if0.mdu_timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_regs: stall_cycles=%0d mdu_timeout=%b, want 0 0", if0.stall_cycles, if0.mdu_timeout); end
        tick();
        idle0(); sys_rst = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL reset_count_held: stall_cycles=%0d want 0", if0.stall_cycles); end
        n_chk++; if ({if0.pc_stall, if0.if_id_stall, if0.if_id_flush, if0.id_ex_valid, if0.id_ex_stall, if0.ex_mem_valid} !== 6'b000101) begin
            n_err++; $display("FAIL reset_idle_outputs: got %b want 000101",
                {if0.pc_stall, if0.if_id_stall, if0.if_id_flush, if0.id_ex_valid, if0.id_ex_stall, if0.ex_mem_valid}); end
        tick();
        exp_stalls = 0;
    endtask

    task automatic test_data_hazard();
`ifdef HAZARD_FORWARD_EN
        idle0(); if0.ex_rd = 5; if0.ex_reg_write = 1; if0.ex_is_load = 1; if0.id_rs1 = 5; if0.id_use_rs1 = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b1 || if0.id_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL load_use: pc_stall=%b id_ex_valid=%b, want 1 0", if0.pc_stall, if0.id_ex_valid); end
        exp_stalls++; tick();
        idle0(); if0.id_rs1 = 5; if0.id_use_rs1 = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL load_use_release: pc_stall=%b want 0", if0.pc_stall); end
        tick();
        if0.ex_rd = 5; if0.ex_reg_write = 1; if0.mem_rd = 5; if0.mem_reg_write = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL forwarded_no_stall: pc_stall=%b want 0", if0.pc_stall); end
        tick();
`else
        idle0(); if0.mem_rd = 7; if0.mem_reg_write = 1; if0.id_rs2 = 7; if0.id_use_rs2 = 1;
        @(negedge sys_clk);
        n_chk++; if ({if0.pc_stall, if0.if_id_stall, if0.id_ex_valid} !== 3'b110) begin
            n_err++; $display("FAIL mem_raw: stall/ifid/idexv=%b want 110", {if0.pc_stall, if0.if_id_stall, if0.id_ex_valid}); end
        exp_stalls++; tick();
        if0.mem_reg_write = 0; if0.mem_rd = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL mem_raw_release: pc_stall=%b want 0", if0.pc_stall); end
        tick();
        if0.ex_rd = 7; if0.ex_reg_write = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b1) begin n_err++; $display("FAIL ex_raw: pc_stall=%b want 1", if0.pc_stall); end
        exp_stalls++; tick();
        if0.ex_rd = 0; if0.ex_reg_write = 0; if0.mem_rd = 7; if0.mem_reg_write = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b1) begin n_err++; $display("FAIL ex_then_mem_raw: pc_stall=%b want 1", if0.pc_stall); end
        exp_stalls++; tick();
        if0.mem_rd = 0; if0.mem_reg_write = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL ex_then_mem_release: pc_stall=%b want 0", if0.pc_stall); end
        tick();
`endif
        idle0(); if0.ex_reg_write = 1; if0.mem_reg_write = 1; if0.id_use_rs1 = 1; if0.id_use_rs2 = 1;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL x0_no_hazard: pc_stall=%b want 0", if0.pc_stall); end
        tick();
        idle0(); if0.ex_rd = 9; if0.ex_reg_write = 1; if0.ex_is_load = 1; if0.id_rs1 = 9; if0.id_use_rs1 = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL unused_src: pc_stall=%b want 0", if0.pc_stall); end
        tick();
        idle0();
        @(negedge sys_clk);
        n_chk++; if (if0.stall_cycles !== 32'(exp_stalls)) begin
            n_err++; $display("FAIL hazard_count: stall_cycles=%0d want %0d", if0.stall_cycles, exp_stalls); end
        tick();
    endtask

    task automatic test_flush();
        idle0();
        if0.ex_pc_sel = 1; if0.ex_rd = 5; if0.ex_reg_write = 1; if0.ex_is_load = 1;
        if0.id_rs1 = 5; if0.id_use_rs1 = 1;
        for (int i = 0; i < int'(FLUSH_T); i++) begin
            @(negedge sys_clk);
            n_chk++; if ({if0.if_id_flush, if0.id_ex_valid, if0.pc_stall} !== 3'b100) begin
                n_err++; $display("FAIL flush_cycle%0d: flush/idexv/stall=%b want 100", i,
                    {if0.if_id_flush, if0.id_ex_valid, if0.pc_stall}); end
            tick();
            if0.ex_pc_sel = 0;
        end
        @(negedge sys_clk);
        n_chk++; if ({if0.if_id_flush, if0.pc_stall} !== 2'b01) begin
            n_err++; $display("FAIL flush_end: flush/stall=%b want 01", {if0.if_id_flush, if0.pc_stall}); end
        exp_stalls++; tick();
        idle0();
    endtask

    task automatic test_mdu();
        int stalls = 0, bubbles = 0;
        idle0(); if0.ex_mdu_start = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) if0.ex_pc_sel = 1;
            @(negedge sys_clk);
            if (if0.pc_stall === 1'b1 && if0.id_ex_stall === 1'b1) stalls++;
            if (if0.ex_mem_valid === 1'b0) bubbles++;
            if (i == 5) begin
                n_chk++; if (if0.if_id_flush !== 1'b0) begin
                    n_err++; $display("FAIL mdu_ignores_redirect: if_id_flush=%b want 0", if0.if_id_flush); end
            end
            tick();
            if0.ex_mdu_start = 0; if0.ex_pc_sel = 0;
        end
        if0.mdu_done = 1;
        @(negedge sys_clk);
        n_chk++; if ({if0.pc_stall, if0.id_ex_stall, if0.ex_mem_valid} !== 3'b001) begin
            n_err++; $display("FAIL mdu_done_release: stall/idexs/exmemv=%b want 001", {if0.pc_stall, if0.id_ex_stall, if0.ex_mem_valid}); end
        tick();
        if0.mdu_done = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0) begin n_err++; $display("FAIL mdu_back_to_run: pc_stall=%b want 0", if0.pc_stall); end
        n_chk++; if (stalls !== 10 || bubbles !== 10) begin
            n_err++; $display("FAIL mdu_wait_len: stalls=%0d bubbles=%0d want 10 10", stalls, bubbles); end
        exp_stalls += 10;
        n_chk++; if (if0.stall_cycles !== 32'(exp_stalls)) begin
            n_err++; $display("FAIL mdu_count: stall_cycles=%0d want %0d", if0.stall_cycles, exp_stalls); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        bit released = 0;
        idle1(); if1.ex_mdu_start = 1;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge sys_clk);
            if (if1.pc_stall === 1'b1) n++;
            else begin
                released = 1;
                n_chk++; if (if1.mdu_timeout !== 1'b0) begin
                    n_err++; $display("FAIL timeout_early: mdu_timeout=%b want 0", if1.mdu_timeout); end
            end
            tick();
            if1.ex_mdu_start = 0;
        end
        n_chk++; if (released !== 1'b1 || n !== int'(MDU_TO1)) begin
            n_err++; $display("FAIL timeout_len: released=%0d stalls=%0d want 1 %0d", released, n, MDU_TO1); end
        @(negedge sys_clk);
        n_chk++; if (if1.mdu_timeout !== 1'b1 || if1.pc_stall !== 1'b0) begin
            n_err++; $display("FAIL timeout_flag: mdu_timeout=%b pc_stall=%b want 1 0", if1.mdu_timeout, if1.pc_stall); end
        tick();
        if1.ex_rd = 4; if1.ex_reg_write = 1; if1.id_rs2 = 4; if1.id_use_rs2 = 1;
        @(negedge sys_clk);
        n_chk++; if (if1.pc_stall !== 1'b1 || if1.mdu_timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_run: pc_stall=%b mdu_timeout=%b want 1 1", if1.pc_stall, if1.mdu_timeout); end
        tick();
        idle1();
    endtask

    task automatic test_reset_mid_mdu();
        idle0(); if0.ex_mdu_start = 1;
        @(negedge sys_clk);
        tick();
        if0.ex_mdu_start = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b1) begin n_err++; $display("FAIL rst_mdu_waiting: pc_stall=%b want 1", if0.pc_stall); end
        tick();
        sys_rst = 0;
        @(negedge sys_clk);
        n_chk++; if (if0.pc_stall !== 1'b0 || if0.ex_mem_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_run_outputs: pc_stall=%b ex_mem_valid=%b want 0 1", if0.pc_stall, if0.ex_mem_valid); end
        tick();
        sys_rst = 1;
        exp_stalls = 0;
        @(negedge sys_clk);
        n_chk++; if ({if0.pc_stall, if0.if_id_stall, if0.id_ex_stall, if0.mdu_timeout, if1.mdu_timeout} !== 5'b0 ||
                     if0.stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_mdu: stalls/flags=%b stall_cycles=%0d want 00000 0",
                {if0.pc_stall, if0.if_id_stall, if0.id_ex_stall, if0.mdu_timeout, if1.mdu_timeout}, if0.stall_cycles); end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] e, o;
        m_flush_left = 0; m_mdu_busy = 0; m_mdu_stalled = 0; m_to = 0;
        for (int c = 0; c < 400; c++) begin
            if0.id_rs1 = 5'($urandom_range(0, 3)); if0.id_rs2 = 5'($urandom_range(0, 3));
            if0.id_use_rs1 = 1'($urandom_range(0, 1)); if0.id_use_rs2 = 1'($urandom_range(0, 1));
            if0.ex_rd = 5'($urandom_range(0, 3)); if0.ex_reg_write = 1'($urandom_range(0, 1));
            if0.ex_is_load = 1'($urandom_range(0, 1));
            if0.mem_rd = 5'($urandom_range(0, 3)); if0.mem_reg_write = 1'($urandom_range(0, 1));
            if0.ex_pc_sel = ($urandom_range(0, 9) == 0);
            if0.ex_mdu_start = ($urandom_range(0, 11) == 0);
            if0.mdu_done = ($urandom_range(0, 3) == 0);
            @(negedge sys_clk);
            n_chk++; if (if0.stall_cycles !== 32'(exp_stalls) || if0.mdu_timeout !== m_to) begin
                n_err++; $display("FAIL rand_regs c%0d: stall_cycles=%0d mdu_timeout=%b want %0d %b",
                    c, if0.stall_cycles, if0.mdu_timeout, exp_stalls, m_to); end
            model_step(e);
            o = {if0.pc_stall, if0.if_id_stall, if0.if_id_flush, if0.id_ex_valid, if0.id_ex_stall, if0.ex_mem_valid};
            n_chk++; if (o !== e) begin
                n_err++; $display("FAIL rand_ctrl c%0d: got %b want %b", c, o, e); end
            tick();
        end
        idle0();
    endtask

    initial begin
        test_reset();
        test_data_hazard();
        test_flush();
        test_mdu();
        test_timeout();
        test_reset_mid_mdu();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
